// File: rtl/led_pattern_sequencer_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_pattern_sequencer_gen_if                                             |
// | Control switches in, LED drive and advance strobe out.                   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface led_pattern_sequencer_gen_if #(
  parameter int N_LEDS = 8
);
  logic [1:0]        speed_sel;
  logic [2:0]        mode;
  logic              dir;
  logic              hold;
  logic              step;
  logic [1:0]        bright;
  logic [N_LEDS-1:0] led_out;
  logic              step_tick;

  // Switch side: drives controls, watches the LEDs.
  modport master (
    output speed_sel, mode, dir, hold, step, bright,
    input  led_out, step_tick
  );

  // Sequencer side.
  modport slave (
    input  speed_sel, mode, dir, hold, step, bright,
    output led_out, step_tick
  );
endinterface
`default_nettype wire

// File: rtl/led_pattern_sequencer_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_pattern_sequencer_gen                                                |
// | Eight generated LED patterns, selectable step rate, direction, hold with |
// | single-step and 4-level PWM brightness.                                  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module led_pattern_sequencer_gen #(
  parameter int                N_LEDS    = 8,
  parameter int                PERIOD0   = 10_000_000,
  parameter int                PERIOD1   = 5_000_000,
  parameter int                PERIOD2   = 2_500_000,
  parameter int                PERIOD3   = 1_000_000,
  parameter logic [N_LEDS-1:0] LFSR_TAPS = 8'hB8
) (
  input wire logic                   clk_10MHz,
  input wire logic                   rstn,
  led_pattern_sequencer_gen_if.slave bus
);

  localparam int PMAX01 = (PERIOD0 > PERIOD1) ? PERIOD0 : PERIOD1;
  localparam int PMAX23 = (PERIOD2 > PERIOD3) ? PERIOD2 : PERIOD3;
  localparam int PMAX   = (PMAX01 > PMAX23) ? PMAX01 : PMAX23;
  localparam int CW     = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [CW-1:0] LIM0 = CW'(PERIOD0 - 1);
  localparam logic [CW-1:0] LIM1 = CW'(PERIOD1 - 1);
  localparam logic [CW-1:0] LIM2 = CW'(PERIOD2 - 1);
  localparam logic [CW-1:0] LIM3 = CW'(PERIOD3 - 1);

  localparam logic [N_LEDS-1:0] TOP_POS = N_LEDS'(N_LEDS - 1);  // ping-pong turn point
  localparam logic [N_LEDS-1:0] TOP_BAR = N_LEDS'(N_LEDS);      // bar fully lit

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_CHASE = 3'd1;
  localparam logic [2:0] MODE_PING  = 3'd2;
  localparam logic [2:0] MODE_BAR   = 3'd3;
  localparam logic [2:0] MODE_BIN   = 3'd4;
  localparam logic [2:0] MODE_GRAY  = 3'd5;
  localparam logic [2:0] MODE_ALT   = 3'd6;
  localparam logic [2:0] MODE_LFSR  = 3'd7;

  // Starting pattern state for each mode; ping-pong and bar start at 0, moving up.
  function automatic logic [N_LEDS-1:0] seed_of(input logic [2:0] m);
    logic [N_LEDS-1:0] s;
    s = '0;
    case (m)
      MODE_CHASE, MODE_LFSR: s = N_LEDS'(1);
      MODE_ALT: for (int i = 0; i < N_LEDS; i += 2) s[i] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  logic [2:0]        mode_q;
  logic              step_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     lim;
  logic [N_LEDS-1:0] state;
  logic [N_LEDS-1:0] state_nx;
  logic              down;      // ping-pong / bar currently moving downwards
  logic              down_nx;
  logic [1:0]        pwm_cnt;
  logic [N_LEDS-1:0] display;
  logic [N_LEDS:0]   bar_wide;
  logic              reload;
  logic              tick;
  logic              step_edge;
  logic              advance;
  logic              pwm_on;

  // Prescaler limit for the selected speed, plus the advance qualifiers.
  always_comb begin
    case (bus.speed_sel)
      2'd0:    lim = LIM0;
      2'd1:    lim = LIM1;
      2'd2:    lim = LIM2;
      default: lim = LIM3;
    endcase
    reload    = (bus.mode != mode_q);
    // >= keeps a shortened period from overrunning a count already past it.
    tick      = !bus.hold && (cnt >= lim);
    step_edge = bus.hold && bus.step && !step_q;
    // A mode reload takes the edge; mode 0 never advances.
    advance   = (tick || step_edge) && !reload && (mode_q != MODE_OFF);
    pwm_on    = (pwm_cnt <= bus.bright);
  end

  // Next pattern state for one advance of the registered mode.
  always_comb begin
    state_nx = state;
    down_nx  = down;
    case (mode_q)
      MODE_CHASE: state_nx = bus.dir ? {state[0], state[N_LEDS-1:1]}
                                     : {state[N_LEDS-2:0], state[N_LEDS-1]};
      MODE_PING: begin
        if (!down) begin
          if (state == TOP_POS) begin
            state_nx = state - 1'b1;
            down_nx  = 1'b1;
          end else begin
            state_nx = state + 1'b1;
          end
        end else if (state == '0) begin
          state_nx = N_LEDS'(1);
          down_nx  = 1'b0;
        end else begin
          state_nx = state - 1'b1;
        end
      end
      MODE_BAR: begin
        if (!down) begin
          if (state == TOP_BAR) begin
            state_nx = state - 1'b1;
            down_nx  = 1'b1;
          end else begin
            state_nx = state + 1'b1;
          end
        end else if (state == '0) begin
          state_nx = N_LEDS'(1);
          down_nx  = 1'b0;
        end else begin
          state_nx = state - 1'b1;
        end
      end
      MODE_BIN, MODE_GRAY: state_nx = bus.dir ? state - 1'b1 : state + 1'b1;
      MODE_ALT:  state_nx = ~state;
      MODE_LFSR: state_nx = state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
      default:   state_nx = state;
    endcase
  end

  // Map pattern state to the LED image for the registered mode.
  always_comb begin
    bar_wide = (N_LEDS + 1)'(1) << state;
    bar_wide = bar_wide - 1'b1;
    case (mode_q)
      MODE_CHASE, MODE_BIN, MODE_ALT, MODE_LFSR: display = state;
      MODE_PING: display = N_LEDS'(1) << state;
      MODE_BAR:  display = bus.dir ? ~bar_wide[N_LEDS-1:0] : bar_wide[N_LEDS-1:0];
      MODE_GRAY: display = state ^ (state >> 1);
      default:   display = '0;
    endcase
  end

  // Mode/step history and the step-rate prescaler.
  always_ff @(posedge clk_10MHz or negedge rstn) begin
    if (!rstn) begin
      mode_q <= MODE_OFF;
      step_q <= 1'b0;
      cnt    <= '0;
    end else begin
      mode_q <= bus.mode;
      step_q <= bus.step;
      if (reload)
        cnt <= '0;
      else if (!bus.hold)
        cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // Pattern state: reload on mode change, otherwise step on each advance.
  always_ff @(posedge clk_10MHz or negedge rstn) begin
    if (!rstn) begin
      state <= seed_of(MODE_OFF);
      down  <= 1'b0;
    end else if (reload) begin
      state <= seed_of(bus.mode);
      down  <= 1'b0;
    end else if (advance) begin
      state <= state_nx;
      down  <= down_nx;
    end
  end

  // Free-running PWM phase and the registered LED/strobe outputs.
  always_ff @(posedge clk_10MHz or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt       <= 2'd0;
      bus.led_out   <= '0;
      bus.step_tick <= 1'b0;
    end else begin
      pwm_cnt       <= pwm_cnt + 1'b1;
      bus.led_out   <= display & {N_LEDS{pwm_on}};
      bus.step_tick <= advance;
    end
  end

endmodule
`default_nettype wire
